// File: rtl/rangefinder_pkg.sv
// rtl/rangefinder_pkg.sv - shared types and constants for the multi-channel range tracker
package rangefinder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READING = 2'd1,
    DONE    = 2'd2,
    ERROR   = 2'd3
  } state_t;

  // Counters narrower than this take their saturation value from the low bits.
  localparam int COUNT_W_MAX = 64;
  localparam logic [COUNT_W_MAX-1:0] COUNT_ALL_ONES = '1;

endpackage

// File: rtl/range_channel.sv
// rtl/range_channel.sv - one channel's min/max/empty/count accumulator and published result
module range_channel
  import rangefinder_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SIGNED  = 0,
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               fold_en,
  input  logic               publish,
  input  logic               valid,
  input  logic [WIDTH-1:0]   data,
  output logic [WIDTH-1:0]   range_out,
  output logic [WIDTH-1:0]   min_out,
  output logic [WIDTH-1:0]   max_out,
  output logic               empty_out,
  output logic [COUNT_W-1:0] count_out
);

  localparam logic [COUNT_W-1:0] COUNT_SAT = COUNT_ALL_ONES[COUNT_W-1:0];

  logic [WIDTH-1:0]   acc_min_q, acc_min_d;
  logic [WIDTH-1:0]   acc_max_q, acc_max_d;
  logic               acc_empty_q, acc_empty_d;
  logic [COUNT_W-1:0] acc_count_q, acc_count_d;

  logic [WIDTH-1:0]   range_q, range_d;
  logic [WIDTH-1:0]   min_q, min_d;
  logic [WIDTH-1:0]   max_q, max_d;
  logic               empty_q, empty_d;
  logic [COUNT_W-1:0] count_q, count_d;

  function automatic logic less_than(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED != 0) begin
      return $signed(a) < $signed(b);
    end
    return a < b;
  endfunction

  // Clear and fold compose in one cycle so a session's first cycle can also carry a sample.
  always_comb begin
    acc_min_d   = acc_min_q;
    acc_max_d   = acc_max_q;
    acc_empty_d = acc_empty_q;
    acc_count_d = acc_count_q;
    if (clear) begin
      acc_min_d   = '0;
      acc_max_d   = '0;
      acc_empty_d = 1'b1;
      acc_count_d = '0;
    end
    if (fold_en && valid) begin
      if (acc_empty_d) begin
        acc_min_d = data;
        acc_max_d = data;
      end else begin
        if (less_than(data, acc_min_d)) acc_min_d = data;
        if (less_than(acc_max_d, data)) acc_max_d = data;
      end
      acc_empty_d = 1'b0;
      if (acc_count_d != COUNT_SAT) acc_count_d = acc_count_d + 1'b1;
    end
  end

  // Publish sees this cycle's folded accumulator so results land one cycle after finish.
  always_comb begin
    range_d = range_q;
    min_d   = min_q;
    max_d   = max_q;
    empty_d = empty_q;
    count_d = count_q;
    if (publish) begin
      empty_d = acc_empty_d;
      count_d = acc_count_d;
      if (acc_empty_d) begin
        range_d = '0;
        min_d   = '0;
        max_d   = '0;
      end else begin
        range_d = acc_max_d - acc_min_d;
        min_d   = acc_min_d;
        max_d   = acc_max_d;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_min_q   <= '0;
      acc_max_q   <= '0;
      acc_empty_q <= 1'b1;
      acc_count_q <= '0;
      range_q     <= '0;
      min_q       <= '0;
      max_q       <= '0;
      empty_q     <= 1'b1;
      count_q     <= '0;
    end else begin
      acc_min_q   <= acc_min_d;
      acc_max_q   <= acc_max_d;
      acc_empty_q <= acc_empty_d;
      acc_count_q <= acc_count_d;
      range_q     <= range_d;
      min_q       <= min_d;
      max_q       <= max_d;
      empty_q     <= empty_d;
      count_q     <= count_d;
    end
  end

  assign range_out = range_q;
  assign min_out   = min_q;
  assign max_out   = max_q;
  assign empty_out = empty_q;
  assign count_out = count_q;

endmodule

// File: rtl/rangefinder_multi.sv
// rtl/rangefinder_multi.sv - session FSM and result strobe over CHANNELS range accumulators
module rangefinder_multi
  import rangefinder_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SIGNED   = 0,
  parameter int COUNT_W  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  go,
  input  logic                  finish,
  input  logic [CHANNELS*WIDTH-1:0]   data_in,
  input  logic [CHANNELS-1:0]         data_valid,
  output logic [CHANNELS*WIDTH-1:0]   range_out,
  output logic [CHANNELS*WIDTH-1:0]   min_out,
  output logic [CHANNELS*WIDTH-1:0]   max_out,
  output logic [CHANNELS-1:0]         empty_out,
  output logic [CHANNELS*COUNT_W-1:0] sample_count,
  output logic                  range_valid,
  output logic                  busy,
  output logic                  debug_error
);

  state_t state_q, state_d;
  logic   range_valid_q, range_valid_d;
  logic   clear, fold_en, publish;

  always_comb begin
    state_d       = state_q;
    range_valid_d = 1'b0;
    clear         = 1'b0;
    fold_en       = 1'b0;
    publish       = 1'b0;
    case (state_q)
      IDLE: begin
        if (go && finish) begin
          state_d = ERROR;
        end else if (go) begin
          state_d = READING;
          clear   = 1'b1;
          fold_en = 1'b1;
        end else if (finish) begin
          state_d = ERROR;
        end
      end
      READING: begin
        if (go && finish) begin
          state_d = ERROR;
          clear   = 1'b1;
        end else if (go) begin
          clear   = 1'b1;
          fold_en = 1'b1;
        end else if (finish) begin
          state_d       = DONE;
          fold_en       = 1'b1;
          publish       = 1'b1;
          range_valid_d = 1'b1;
        end else begin
          fold_en = 1'b1;
        end
      end
      DONE: begin
        if (go && finish) begin
          state_d = ERROR;
        end else if (go) begin
          state_d = READING;
          clear   = 1'b1;
          fold_en = 1'b1;
        end else if (finish) begin
          state_d = ERROR;
        end else begin
          state_d = IDLE;
        end
      end
      ERROR: begin
        if (go && !finish) begin
          state_d = READING;
          clear   = 1'b1;
          fold_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      range_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      range_valid_q <= range_valid_d;
    end
  end

  assign range_valid = range_valid_q;
  assign busy        = (state_q == READING);
  assign debug_error = (state_q == ERROR);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    range_channel #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED),
      .COUNT_W(COUNT_W)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .clear    (clear),
      .fold_en  (fold_en),
      .publish  (publish),
      .valid    (data_valid[c]),
      .data     (data_in[c*WIDTH +: WIDTH]),
      .range_out(range_out[c*WIDTH +: WIDTH]),
      .min_out  (min_out[c*WIDTH +: WIDTH]),
      .max_out  (max_out[c*WIDTH +: WIDTH]),
      .empty_out(empty_out[c]),
      .count_out(sample_count[c*COUNT_W +: COUNT_W])
    );
  end

endmodule

// File: tb/tb_rangefinder_multi.sv
// tb/tb_rangefinder_multi.sv - directed scoreboard bench for rangefinder_multi
module tb_rangefinder_multi;

  logic        clock;
  logic        reset;
  logic        go, finish;
  logic [63:0] data_in;
  logic [3:0]  data_valid;
  logic [63:0] range_out, min_out, max_out, sample_count;
  logic [3:0]  empty_out;
  logic        range_valid, busy, debug_error;

  logic        go8, fin8;
  logic [15:0] d8;
  logic [1:0]  dv8;
  logic [15:0] rng_s, mn_s, mx_s, rng_u, mn_u, mx_u;
  logic [1:0]  emp_s, emp_u;
  logic [5:0]  cnt_s, cnt_u;
  logic        rv_s, busy_s, dbg_s, rv_u, busy_u, dbg_u;

  rangefinder_multi dut (
    .clock(clock), .reset(reset), .go(go), .finish(finish),
    .data_in(data_in), .data_valid(data_valid),
    .range_out(range_out), .min_out(min_out), .max_out(max_out),
    .empty_out(empty_out), .sample_count(sample_count),
    .range_valid(range_valid), .busy(busy), .debug_error(debug_error)
  );

  rangefinder_multi #(.WIDTH(8), .CHANNELS(2), .SIGNED(1), .COUNT_W(3)) dut_s (
    .clock(clock), .reset(reset), .go(go8), .finish(fin8),
    .data_in(d8), .data_valid(dv8),
    .range_out(rng_s), .min_out(mn_s), .max_out(mx_s),
    .empty_out(emp_s), .sample_count(cnt_s),
    .range_valid(rv_s), .busy(busy_s), .debug_error(dbg_s)
  );

  rangefinder_multi #(.WIDTH(8), .CHANNELS(2), .SIGNED(0), .COUNT_W(3)) dut_u (
    .clock(clock), .reset(reset), .go(go8), .finish(fin8),
    .data_in(d8), .data_valid(dv8),
    .range_out(rng_u), .min_out(mn_u), .max_out(mx_u),
    .empty_out(emp_u), .sample_count(cnt_u),
    .range_valid(rv_u), .busy(busy_u), .debug_error(dbg_u)
  );

  typedef struct {
    logic [63:0] rng, mn, mx, cnt;
    logic [3:0]  emp;
  } exp_t;

  typedef struct {
    logic [15:0] rng, mn, mx;
    logic [5:0]  cnt;
    logic [1:0]  emp;
  } exp8_t;

  exp_t  q_main[$];
  exp8_t q_s[$], q_u[$];
  exp_t  last_main;

  logic [15:0] mmin[4], mmax[4];
  int          mcnt[4];
  bit          memp[4];

  int n_assert = 0;
  int n_fail   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    for (int c = 0; c < 4; c++) begin
      memp[c] = 1'b1; mcnt[c] = 0; mmin[c] = '0; mmax[c] = '0;
    end
  endtask

  task automatic m_fold(input logic [3:0] v, input logic [63:0] d);
    logic [15:0] w;
    for (int c = 0; c < 4; c++) begin
      if (v[c]) begin
        w = d[c*16 +: 16];
        if (memp[c]) begin
          mmin[c] = w; mmax[c] = w;
        end else begin
          if (w < mmin[c]) mmin[c] = w;
          if (w > mmax[c]) mmax[c] = w;
        end
        memp[c] = 1'b0;
        if (mcnt[c] < 65535) mcnt[c]++;
      end
    end
  endtask

  function automatic exp_t m_result();
    exp_t e;
    e.rng = '0; e.mn = '0; e.mx = '0; e.cnt = '0; e.emp = '0;
    for (int c = 0; c < 4; c++) begin
      e.emp[c] = memp[c];
      e.cnt[c*16 +: 16] = 16'(mcnt[c]);
      if (!memp[c]) begin
        e.rng[c*16 +: 16] = mmax[c] - mmin[c];
        e.mn[c*16 +: 16]  = mmin[c];
        e.mx[c*16 +: 16]  = mmax[c];
      end
    end
    return e;
  endfunction

  task automatic check_main(input string tag, input exp_t e);
    chk({tag, "_range"}, range_out, e.rng);
    chk({tag, "_min"}, min_out, e.mn);
    chk({tag, "_max"}, max_out, e.mx);
    chk({tag, "_count"}, sample_count, e.cnt);
    chk({tag, "_empty"}, 64'(empty_out), 64'(e.emp));
  endtask

  task automatic check8(input string tag, input exp8_t e, input logic [15:0] r,
                        input logic [15:0] mn, input logic [15:0] mx,
                        input logic [5:0] cn, input logic [1:0] em);
    chk({tag, "_range"}, 64'(r), 64'(e.rng));
    chk({tag, "_min"}, 64'(mn), 64'(e.mn));
    chk({tag, "_max"}, 64'(mx), 64'(e.mx));
    chk({tag, "_count"}, 64'(cn), 64'(e.cnt));
    chk({tag, "_empty"}, 64'(em), 64'(e.emp));
  endtask

  // Advance one clock and retire any published result against the scoreboard.
  task automatic tick();
    exp_t  e;
    exp8_t e8;
    @(posedge clock);
    #1;
    if (range_valid) begin
      chk("main_strobe_expected", 64'(q_main.size() != 0), 64'd1);
      if (q_main.size() != 0) begin
        e = q_main.pop_front();
        check_main("main_result", e);
        last_main = e;
      end
    end
    if (rv_s) begin
      chk("s_strobe_expected", 64'(q_s.size() != 0), 64'd1);
      if (q_s.size() != 0) begin
        e8 = q_s.pop_front();
        check8("s_result", e8, rng_s, mn_s, mx_s, cnt_s, emp_s);
      end
    end
    if (rv_u) begin
      chk("u_strobe_expected", 64'(q_u.size() != 0), 64'd1);
      if (q_u.size() != 0) begin
        e8 = q_u.pop_front();
        check8("u_result", e8, rng_u, mn_u, mx_u, cnt_u, emp_u);
      end
    end
  endtask

  task automatic drv(input logic g, input logic f, input logic [3:0] v, input logic [63:0] d);
    go = g; finish = f; data_valid = v; data_in = d;
  endtask

  initial begin
    exp8_t e8;
    reset = 1'b1;
    drv(0, 0, 4'b0, 64'd0);
    go8 = 0; fin8 = 0; dv8 = 2'b00; d8 = '0;
    tick();
    tick();
    reset = 1'b0;

    last_main.rng = '0; last_main.mn = '0; last_main.mx = '0;
    last_main.cnt = '0; last_main.emp = 4'hF;
    check_main("reset", last_main);
    chk("reset_range_valid", 64'(range_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_debug_error", 64'(debug_error), 64'd0);
    chk("reset_s_empty", 64'(emp_s), 64'h3);

    // Session: ch0 5,9,2,7; ch2 never valid; ch1/ch3 partial; invalid data ignored.
    drv(1, 0, 4'b1011, {16'hFFFF, 16'd0, 16'd100, 16'd5});
    m_clear(); m_fold(data_valid, data_in); tick();
    chk("t1_busy", 64'(busy), 64'd1);
    drv(0, 0, 4'b1011, {16'd1, 16'd0, 16'd50, 16'd9});
    m_fold(data_valid, data_in); tick();
    drv(0, 0, 4'b0001, {16'd0, 16'd0, 16'd0, 16'd2});
    m_fold(data_valid, data_in); tick();
    drv(0, 0, 4'b0000, {16'd0, 16'd0, 16'd0, 16'd0});
    m_fold(data_valid, data_in); tick();
    drv(0, 1, 4'b1001, {16'h8000, 16'd0, 16'd0, 16'd7});
    m_fold(data_valid, data_in); q_main.push_back(m_result()); tick();
    chk("t1_strobe_high", 64'(range_valid), 64'd1);
    chk("t1_ch0_range", 64'(range_out[15:0]), 64'd7);
    drv(0, 0, 4'b0000, 64'd0);
    tick();
    chk("t1_strobe_one_cycle", 64'(range_valid), 64'd0);
    check_main("t1_held", last_main);

    // go&&finish mid-session, finish alone in ERROR, then go exits.
    drv(1, 0, 4'b0001, {48'd0, 16'd1000});
    m_clear(); m_fold(data_valid, data_in); tick();
    drv(1, 1, 4'b1111, {16'd1, 16'd2, 16'd3, 16'd4});
    tick();
    chk("t3_error", 64'(debug_error), 64'd1);
    chk("t3_not_busy", 64'(busy), 64'd0);
    check_main("t3_outputs_kept", last_main);
    drv(0, 1, 4'b0000, 64'd0);
    tick();
    chk("t3_finish_stays_error", 64'(debug_error), 64'd1);
    drv(1, 0, 4'b0100, {16'd0, 16'd123, 32'd0});
    m_clear(); m_fold(data_valid, data_in); tick();
    chk("t3_exit_error", 64'(debug_error), 64'd0);
    chk("t3_exit_busy", 64'(busy), 64'd1);
    drv(0, 1, 4'b0100, {16'd0, 16'd23, 32'd0});
    m_fold(data_valid, data_in); q_main.push_back(m_result()); tick();
    drv(0, 0, 4'b0000, 64'd0);
    tick();
    check_main("t3_held", last_main);

    // Reset in the middle of a session.
    drv(1, 0, 4'b1111, {4{16'h1234}});
    tick();
    drv(0, 0, 4'b1111, {4{16'h0042}});
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drv(0, 0, 4'b0000, 64'd0);
    last_main.rng = '0; last_main.mn = '0; last_main.mx = '0;
    last_main.cnt = '0; last_main.emp = 4'hF;
    check_main("t6_reset", last_main);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_debug_error", 64'(debug_error), 64'd0);
    chk("t6_range_valid", 64'(range_valid), 64'd0);

    // Single-sample session, then go straight out of DONE into a new one.
    drv(1, 0, 4'b0001, {48'd0, 16'd42});
    m_clear(); m_fold(data_valid, data_in); tick();
    drv(0, 1, 4'b0000, 64'd0);
    q_main.push_back(m_result()); tick();
    drv(1, 0, 4'b0010, {32'd0, 16'd7, 16'd0});
    m_clear(); m_fold(data_valid, data_in); tick();
    chk("done_go_busy", 64'(busy), 64'd1);
    drv(0, 1, 4'b0010, {32'd0, 16'd3, 16'd0});
    m_fold(data_valid, data_in); q_main.push_back(m_result()); tick();
    drv(0, 0, 4'b0000, 64'd0);
    tick();

    // Signed vs unsigned: -3 then 4 on ch0, ch1 idle.
    go8 = 1; fin8 = 0; dv8 = 2'b01; d8 = {8'h00, 8'hFD};
    tick();
    go8 = 0; fin8 = 1; dv8 = 2'b01; d8 = {8'h00, 8'h04};
    e8 = '{rng: 16'h0007, mn: 16'h00FD, mx: 16'h0004, cnt: 6'o02, emp: 2'b10};
    q_s.push_back(e8);
    e8 = '{rng: 16'h00F9, mn: 16'h0004, mx: 16'h00FD, cnt: 6'o02, emp: 2'b10};
    q_u.push_back(e8);
    tick();
    chk("t2_s_strobe", 64'(rv_s), 64'd1);

    // Ten valid samples on both channels: count saturates at 7.
    for (int i = 0; i < 10; i++) begin
      go8 = (i == 0); fin8 = (i == 9); dv8 = 2'b11;
      d8 = {8'(200 - i), 8'(i)};
      if (i == 9) begin
        e8 = '{rng: 16'h0909, mn: 16'hBF00, mx: 16'hC809, cnt: 6'o77, emp: 2'b00};
        q_s.push_back(e8);
        q_u.push_back(e8);
      end
      tick();
    end

    // go mid-session restarts; the go-cycle sample is the only one counted.
    go8 = 1; fin8 = 0; dv8 = 2'b11; d8 = {8'd50, 8'd1};
    tick();
    go8 = 0; d8 = {8'd60, 8'd2};
    tick();
    go8 = 1; dv8 = 2'b01; d8 = {8'd0, 8'h10};
    tick();
    chk("t5_restart_busy", 64'(busy_s), 64'd1);
    go8 = 0; fin8 = 1; dv8 = 2'b00; d8 = '0;
    e8 = '{rng: 16'h0000, mn: 16'h0010, mx: 16'h0010, cnt: 6'o01, emp: 2'b10};
    q_s.push_back(e8);
    q_u.push_back(e8);
    tick();
    fin8 = 0;
    tick();
    chk("t5_u_strobe_low", 64'(rv_u), 64'd0);

    chk("main_queue_drained", 64'(q_main.size()), 64'd0);
    chk("s_queue_drained", 64'(q_s.size()), 64'd0);
    chk("u_queue_drained", 64'(q_u.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
